// File: rtl/wait_state_mem.sv
// Cycle-accurate memory model with a request/ready handshake and separate read/write wait states.
// Define WAIT_STATE_MEM_BYTE_ENABLE_EN to add a per-lane byte_en input for writes.
module wait_state_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
  input  logic [DATA_W/8-1:0] byte_en,
`endif
  output logic [DATA_W-1:0]   read_data,
  output logic                ready,
  output logic                busy,
  output logic                misaligned,
  output logic [1:0]          state_dbg
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int NB      = DATA_W / 8;
  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: read/write are levels held until ready; a request is accepted
  // only on an edge in IDLE, ready is a one-cycle pulse in DONE, and busy
  // covers WAIT and DONE.

  logic [DATA_W-1:0] mem_data [0:DEPTH-1];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              mis_q, mis_d;

  logic [NB-1:0]     req_be;
  logic [NB-1:0]     commit_be;
  logic              req_any;
  logic              req_lat_one;
  logic              accept;
  logic              commit;
  logic              commit_wr;
  logic              mem_we;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  commit_idx;
  logic [DATA_W-1:0] commit_wdata;
  logic              unused_addr;

`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
  logic [NB-1:0] be_q, be_d;
  assign req_be = byte_en;
`else
  assign req_be = '1;
`endif

  assign unused_addr = ^address;
  assign req_any     = read | write;
  assign req_idx     = address[IDX_W+1:2];
  // The write wins a simultaneous read/write, so it also picks the latency.
  assign req_lat_one = write ? (WR_LAT == 1) : (RD_LAT == 1);
  assign accept      = (state_q == S_IDLE) && req_any;

  // A LAT==1 request commits on its own acceptance edge, before anything is latched.
  assign commit = (accept && req_lat_one) || ((state_q == S_WAIT) && (cnt_q == CNT_ONE));

  always_comb begin
    commit_idx   = idx_q;
    commit_wr    = is_wr_q;
    commit_wdata = wdata_q;
`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
    commit_be    = be_q;
`else
    commit_be    = '1;
`endif
    if (state_q == S_IDLE) begin
      commit_idx   = req_idx;
      commit_wr    = write;
      commit_wdata = write_data;
      commit_be    = req_be;
    end
  end

  // Gated by reset so a request held during reset can never touch the array.
  assign mem_we = commit && commit_wr && reset;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      mis_q       <= 1'b0;
`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
      be_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      read_data_q <= read_data_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      mis_q       <= mis_d;
`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
      be_q        <= be_d;
`endif
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_any) state_d = req_lat_one ? S_DONE : S_WAIT;
      S_WAIT: if (cnt_q == CNT_ONE) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and request latches
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    read_data_d = read_data_q;
    mis_d       = mis_q;
    ready_d     = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
    be_d        = be_q;
`endif
    if (accept) begin
      idx_d   = req_idx;
      wdata_d = write_data;
      is_wr_d = write;
      cnt_d   = write ? WR_LOAD : RD_LOAD;
      mis_d   = (address[1:0] != 2'b00);
`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
      be_d    = byte_en;
`endif
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q - CNT_ONE;
    end
    if (commit && !commit_wr) begin
      read_data_d = mem_data[commit_idx];
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (commit_be[i]) mem_data[commit_idx][8*i +: 8] <= commit_wdata[8*i +: 8];
      end
    end
  end

  assign read_data  = read_data_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign misaligned = mis_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_wait_state_mem.sv
// Bench for wait_state_mem: two instances (fast write / slow write) checked
// against a word-level reference model; byte-lane test only with WAIT_STATE_MEM_BYTE_ENABLE_EN.
module tb_wait_state_mem;

  localparam int A_RD = 3, A_WR = 1, A_DEPTH = 1024;
  localparam int B_RD = 4, B_WR = 4, B_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd [2];
  logic        wr [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata_o [2];
  logic        ready_o [2];
  logic        busy_o [2];
  logic        mis_o [2];
  logic [1:0]  st_o [2];
`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
  logic [3:0]  be [2];
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [int];
  logic [31:0] last_rd [2];
  logic [31:0] exp_q [$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  wait_state_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(A_DEPTH), .RD_LAT(A_RD), .WR_LAT(A_WR)) dut_a (
    .clk(clk), .reset(rst_n), .read(rd[0]), .write(wr[0]), .address(addr[0]),
    .write_data(wdata[0]),
`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
    .byte_en(be[0]),
`endif
    .read_data(rdata_o[0]), .ready(ready_o[0]), .busy(busy_o[0]),
    .misaligned(mis_o[0]), .state_dbg(st_o[0])
  );

  wait_state_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(B_DEPTH), .RD_LAT(B_RD), .WR_LAT(B_WR)) dut_b (
    .clk(clk), .reset(rst_n), .read(rd[1]), .write(wr[1]), .address(addr[1]),
    .write_data(wdata[1]),
`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
    .byte_en(be[1]),
`endif
    .read_data(rdata_o[1]), .ready(ready_o[1]), .busy(busy_o[1]),
    .misaligned(mis_o[1]), .state_dbg(st_o[1])
  );

  // reference model
  function automatic int lat_of(input int d, input bit w);
    if (d == 0) return w ? A_WR : A_RD;
    return w ? B_WR : B_RD;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? A_DEPTH : B_DEPTH;
  endfunction

  task automatic model_op(input int d, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] bmask,
                          output int exp_lat, output logic [31:0] exp_rd, output logic exp_mis);
    int idx;
    int key;
    logic [31:0] word;
    idx = int'((a >> 2) % 32'(depth_of(d)));
    key = d * 100000 + idx;
    exp_mis = (a % 4) != 0;
    if (w) begin
      word = mdl.exists(key) ? mdl[key] : 32'h0;
      for (int i = 0; i < 4; i++) if (bmask[i]) word[8*i +: 8] = wd[8*i +: 8];
      mdl[key] = word;
      exp_lat = lat_of(d, 1'b1);
    end else begin
      if (r) last_rd[d] = mdl.exists(key) ? mdl[key] : 32'h0;
      exp_lat = lat_of(d, 1'b0);
    end
    exp_rd = last_rd[d];
  endtask

  // driver: holds the request through the DONE cycle, then drops it
  task automatic do_op(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] bmask,
                       output int lat, output int busy_cyc, output logic [31:0] rdat,
                       output logic mis, output logic rdy_after, output logic busy_after);
    @(negedge clk);
    rd[d] = r;
    wr[d] = w;
    addr[d] = a;
    wdata[d] = wd;
`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
    be[d] = bmask;
`else
    if (bmask == 4'h0) rdat = '0;
`endif
    lat = 0;
    busy_cyc = 0;
    rdat = '0;
    mis = 1'b0;
    rdy_after = 1'b1;
    busy_after = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (busy_o[d]) busy_cyc++;
      if (ready_o[d]) begin
        lat = k;
        rdat = rdata_o[d];
        mis = mis_o[d];
        break;
      end
    end
    if (lat != 0) begin
      @(posedge clk);
      #1;
      rdy_after = ready_o[d];
      busy_after = busy_o[d];
    end
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
      be[d] = 4'hF;
`endif
      last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++; if (ready_o[d] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 0", d, ready_o[d]); end
      total++; if (busy_o[d] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy_o[d]); end
      total++; if (mis_o[d] !== 1'b0) begin bad++; $display("FAIL reset_mis[%0d]: got %b want 0", d, mis_o[d]); end
      total++; if (rdata_o[d] !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, rdata_o[d]); end
      total++; if (st_o[d] !== 2'd0) begin bad++; $display("FAIL reset_state[%0d]: got %0d want 0", d, st_o[d]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic preload();
    int lat, bc, el; logic [31:0] rdat, er; logic mis, ra, ba, em;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32 && i < depth_of(d); i++) begin
        logic [31:0] v;
        v = $urandom;
        model_op(d, 1'b0, 1'b1, 32'(i * 4), v, 4'hF, el, er, em);
        do_op(d, 1'b0, 1'b1, 32'(i * 4), v, 4'hF, lat, bc, rdat, mis, ra, ba);
        total++; if (lat !== el) begin bad++; $display("FAIL preload_lat[%0d]: got %0d want %0d", d, lat, el); end
      end
    end
  endtask

  task automatic test_wait_read();
    int lat, bc, el; logic [31:0] rdat, er; logic mis, ra, ba, em;
    model_op(0, 1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF, el, er, em);
    do_op(0, 1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF, lat, bc, rdat, mis, ra, ba);
    model_op(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF, el, er, em);
    do_op(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF, lat, bc, rdat, mis, ra, ba);
    total++; if (lat !== 3) begin bad++; $display("FAIL wait_read_lat: got %0d want 3", lat); end
    total++; if (bc !== 3) begin bad++; $display("FAIL wait_read_busy: got %0d want 3", bc); end
    total++; if (rdat !== 32'hDEADBEEF || rdat !== er) begin bad++; $display("FAIL wait_read_data: got %h want deadbeef", rdat); end
    total++; if (ra !== 1'b0) begin bad++; $display("FAIL wait_read_pulse: got %b want 0", ra); end
    total++; if (ba !== 1'b0) begin bad++; $display("FAIL wait_read_idle: got %b want 0", ba); end
  endtask

  task automatic test_write_read();
    int lat, bc, el; logic [31:0] rdat, er; logic mis, ra, ba, em;
    model_op(0, 1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF, el, er, em);
    do_op(0, 1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF, lat, bc, rdat, mis, ra, ba);
    total++; if (lat !== 1) begin bad++; $display("FAIL wr_lat: got %0d want 1", lat); end
    total++; if (rdat !== er) begin bad++; $display("FAIL wr_keeps_rdata: got %h want %h", rdat, er); end
    total++; if (ba !== 1'b0) begin bad++; $display("FAIL wr_no_accept_in_done: busy %b want 0", ba); end
    model_op(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, el, er, em);
    do_op(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, lat, bc, rdat, mis, ra, ba);
    total++; if (rdat !== 32'h12345678) begin bad++; $display("FAIL raw_data: got %h want 12345678", rdat); end
  endtask

  task automatic test_simultaneous();
    int lat, bc, el; logic [31:0] rdat, er; logic mis, ra, ba, em;
    model_op(0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, el, er, em);
    do_op(0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, lat, bc, rdat, mis, ra, ba);
    total++; if (lat !== A_WR) begin bad++; $display("FAIL simul_lat: got %0d want %0d", lat, A_WR); end
    total++; if (rdat !== er) begin bad++; $display("FAIL simul_rdata_kept: got %h want %h", rdat, er); end
    model_op(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, el, er, em);
    do_op(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, lat, bc, rdat, mis, ra, ba);
    total++; if (rdat !== 32'hA5A5A5A5) begin bad++; $display("FAIL simul_mem: got %h want a5a5a5a5", rdat); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, el, pulses; logic [31:0] rdat, er; logic mis, ra, ba, em;
    model_op(1, 1'b0, 1'b1, 32'h1C, 32'h00007777, 4'hF, el, er, em);
    do_op(1, 1'b0, 1'b1, 32'h1C, 32'h00007777, 4'hF, lat, bc, rdat, mis, ra, ba);
    @(negedge clk);
    wr[1] = 1'b1; addr[1] = 32'h1D; wdata[1] = 32'h0000CAFE;
    @(posedge clk);
    #1;
    total++; if (busy_o[1] !== 1'b1) begin bad++; $display("FAIL mid_accept_busy: got %b want 1", busy_o[1]); end
    total++; if (mis_o[1] !== 1'b1) begin bad++; $display("FAIL mid_accept_mis: got %b want 1", mis_o[1]); end
    pulses = 0;
    repeat (2) begin @(posedge clk); #1; if (ready_o[1]) pulses++; end
    rst_n = 1'b0;
    #1;
    wr[1] = 1'b0;
    total++; if (busy_o[1] !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy_o[1]); end
    total++; if (mis_o[1] !== 1'b0) begin bad++; $display("FAIL mid_mis: got %b want 0", mis_o[1]); end
    total++; if (st_o[1] !== 2'd0) begin bad++; $display("FAIL mid_state: got %0d want 0", st_o[1]); end
    total++; if (rdata_o[0] !== 32'h0) begin bad++; $display("FAIL mid_rdata_a: got %h want 0", rdata_o[0]); end
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) begin @(posedge clk); #1; if (ready_o[1]) pulses++; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (ready_o[1]) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_no_ready: got %0d pulses want 0", pulses); end
    model_op(1, 1'b1, 1'b0, 32'h1C, 32'h0, 4'hF, el, er, em);
    do_op(1, 1'b1, 1'b0, 32'h1C, 32'h0, 4'hF, lat, bc, rdat, mis, ra, ba);
    total++; if (lat !== B_RD) begin bad++; $display("FAIL mid_after_lat: got %0d want %0d", lat, B_RD); end
    total++; if (rdat !== 32'h00007777 || rdat !== er) begin bad++; $display("FAIL mid_write_dropped: got %h want 00007777", rdat); end
  endtask

  task automatic test_misaligned_wrap();
    int lat, bc, el; logic [31:0] rdat, er; logic mis, ra, ba, em;
    model_op(0, 1'b1, 1'b0, 32'h00001006, 32'h0, 4'hF, el, er, em);
    do_op(0, 1'b1, 1'b0, 32'h00001006, 32'h0, 4'hF, lat, bc, rdat, mis, ra, ba);
    total++; if (mis !== 1'b1) begin bad++; $display("FAIL wrap_mis: got %b want 1", mis); end
    total++; if (rdat !== mdl[1]) begin bad++; $display("FAIL wrap_data: got %h want %h", rdat, mdl[1]); end
    model_op(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, el, er, em);
    do_op(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, lat, bc, rdat, mis, ra, ba);
    total++; if (mis !== 1'b0) begin bad++; $display("FAIL aligned_mis: got %b want 0", mis); end
  endtask

  task automatic test_random();
    int lat, bc, el, d, idx, op; logic [31:0] rdat, er, a, wd, exp_rd; logic mis, ra, ba, em;
    logic [3:0] bm;
    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(0, 1));
      idx = int'($urandom_range(0, (d == 0) ? 31 : 15));
      a = 32'(((int'($urandom_range(0, 7)) * depth_of(d)) + idx) * 4) | 32'($urandom_range(0, 3));
      op = int'($urandom_range(0, 2));
      wd = $urandom;
`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
      bm = 4'($urandom_range(0, 15));
`else
      bm = 4'hF;
`endif
      model_op(d, op != 1, op != 0, a, wd, bm, el, er, em);
      exp_q.push_back(er);
      do_op(d, op != 1, op != 0, a, wd, bm, lat, bc, rdat, mis, ra, ba);
      exp_rd = exp_q.pop_front();
      total++; if (lat !== el) begin bad++; $display("FAIL rand_lat[%0d]: got %0d want %0d", n, lat, el); end
      total++; if (rdat !== exp_rd) begin bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, rdat, exp_rd); end
      total++; if (mis !== em) begin bad++; $display("FAIL rand_mis[%0d]: got %b want %b", n, mis, em); end
      total++; if (ra !== 1'b0) begin bad++; $display("FAIL rand_pulse[%0d]: got %b want 0", n, ra); end
    end
  endtask

`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
  task automatic test_byte_en();
    int lat, bc, el; logic [31:0] rdat, er; logic mis, ra, ba, em;
    model_op(0, 1'b0, 1'b1, 32'hC, 32'h11223344, 4'hF, el, er, em);
    do_op(0, 1'b0, 1'b1, 32'hC, 32'h11223344, 4'hF, lat, bc, rdat, mis, ra, ba);
    model_op(0, 1'b0, 1'b1, 32'hC, 32'hAABBCCDD, 4'b0101, el, er, em);
    do_op(0, 1'b0, 1'b1, 32'hC, 32'hAABBCCDD, 4'b0101, lat, bc, rdat, mis, ra, ba);
    model_op(0, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0, el, er, em);
    do_op(0, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0, lat, bc, rdat, mis, ra, ba);
    total++; if (rdat !== 32'h11BB33DD) begin bad++; $display("FAIL be_merge: got %h want 11bb33dd", rdat); end
    model_op(0, 1'b0, 1'b1, 32'hC, 32'hFFFFFFFF, 4'h0, el, er, em);
    do_op(0, 1'b0, 1'b1, 32'hC, 32'hFFFFFFFF, 4'h0, lat, bc, rdat, mis, ra, ba);
    total++; if (lat !== A_WR) begin bad++; $display("FAIL be_zero_ready: got %0d want %0d", lat, A_WR); end
    model_op(0, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0, el, er, em);
    do_op(0, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0, lat, bc, rdat, mis, ra, ba);
    total++; if (rdat !== 32'h11BB33DD) begin bad++; $display("FAIL be_zero_nochange: got %h want 11bb33dd", rdat); end
  endtask
`endif

  initial begin
    test_reset();
    preload();
    test_wait_read();
    test_write_read();
    test_simultaneous();
    test_reset_mid();
    test_misaligned_wrap();
`ifdef WAIT_STATE_MEM_BYTE_ENABLE_EN
    test_byte_en();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
